// File: rtl/reduction_mux_n.sv
// N-input output-port mux for the torus crossbar: per-port FWFT FIFOs, priority/round-robin
// arbitration, and a three-stage pipeline (FR -> RR -> WB) with an in-network reduction table.
module reduction_mux_n #(
    parameter int NumPorts        = 7,
    parameter int DataWidth       = 256,
    parameter int FIFODepth       = 4,
    parameter int PriorityPos     = 152,
    parameter int PriorityWidth   = 8,
    parameter int ReductionBitPos = 254,
    parameter int IndexPos        = 128,
    parameter int IndexWidth      = 8,
    parameter int WeightPos       = 144,
    parameter int WeightWidth     = 8,
    parameter int PayloadLen      = 128,
    parameter int CntWidth        = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NumPorts*DataWidth-1:0] in,
    input  logic [NumPorts-1:0]           in_pipeline_stall,
    output logic [NumPorts-1:0]           in_avail,
    input  logic                          out_stall,
    input  logic                          cfg_we,
    input  logic [IndexWidth-1:0]         cfg_index,
    input  logic [CntWidth-1:0]           cfg_expect,
    output logic [DataWidth-1:0]          out,
    output logic                          send
);

    localparam int PtrW      = $clog2(FIFODepth);
    localparam int PortW     = $clog2(NumPorts);
    localparam int TableSize = 1 << IndexWidth;
    localparam int WaccLsb   = PayloadLen;
    localparam int CntLsb    = PayloadLen + WeightWidth;
    localparam int ExpLsb    = CntLsb + CntWidth;
    localparam int EntryW    = ExpLsb + CntWidth;

    // ---------------- input FIFOs ----------------
    logic [DataWidth-1:0] fifo_mem [NumPorts][FIFODepth];
    logic [PtrW:0]        wr_ptr   [NumPorts];
    logic [PtrW:0]        rd_ptr   [NumPorts];
    logic [DataWidth-1:0] head     [NumPorts];
    logic [NumPorts-1:0]  empty, full, wr_en, pop;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) begin
            empty[p] = (wr_ptr[p] == rd_ptr[p]);
            full[p]  = (wr_ptr[p][PtrW] != rd_ptr[p][PtrW]) &&
                       (wr_ptr[p][PtrW-1:0] == rd_ptr[p][PtrW-1:0]);
            head[p]  = fifo_mem[p][rd_ptr[p][PtrW-1:0]];
            wr_en[p] = in[p*DataWidth + DataWidth-1] & ~in_pipeline_stall[p] & ~full[p];
        end
    end

    assign in_avail = ~full;

    always_ff @(posedge clk) begin
        for (int p = 0; p < NumPorts; p++) begin
            if (wr_en[p]) fifo_mem[p][wr_ptr[p][PtrW-1:0]] <= in[p*DataWidth +: DataWidth];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NumPorts; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
            end
        end else begin
            for (int p = 0; p < NumPorts; p++) begin
                if (wr_en[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])   rd_ptr[p] <= rd_ptr[p] + 1'b1;
            end
        end
    end

    // ---------------- FR: arbitration ----------------
    logic [PortW-1:0]         rr_ptr;
    logic                     grant_valid;
    logic [PortW-1:0]         grant_port;
    logic [PriorityWidth-1:0] best_prio;
    logic [PriorityWidth-1:0] cand_prio;
    int                       idx;

    // Scanning from rr_ptr with a strict '>' gives ties to the first port in round-robin order.
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = '0;
        best_prio   = '0;
        cand_prio   = '0;
        idx         = 0;
        for (int k = 0; k < NumPorts; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NumPorts) idx = idx - NumPorts;
            cand_prio = head[idx][PriorityPos +: PriorityWidth];
            if (!empty[idx] && (!grant_valid || cand_prio > best_prio)) begin
                grant_valid = 1'b1;
                grant_port  = PortW'(idx);
                best_prio   = cand_prio;
            end
        end
    end

    always_comb begin
        pop = '0;
        if (grant_valid && !out_stall) pop[grant_port] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_valid && !out_stall) begin
            if (grant_port == PortW'(NumPorts-1)) rr_ptr <= '0;
            else                                   rr_ptr <= grant_port + 1'b1;
        end
    end

    // ---------------- pipeline registers ----------------
    logic                 s1_valid, s2_valid;
    logic [DataWidth-1:0] s1_pkt, s2_pkt;
    logic [EntryW-1:0]    s2_entry;
    logic [EntryW-1:0]    rd_entry;
    logic [EntryW-1:0]    red_table [TableSize];

    logic                   wb_we;
    logic [IndexWidth-1:0]  wb_index, s1_index;
    logic [EntryW-1:0]      wb_data, cfg_data;

    assign s1_index = s1_pkt[IndexPos +: IndexWidth];
    assign wb_index = s2_pkt[IndexPos +: IndexWidth];
    assign cfg_data = {cfg_expect, {(EntryW-CntWidth){1'b0}}};

    // RR sees whatever the table will hold after this edge, so same-index packets chain correctly.
    always_comb begin
        rd_entry = red_table[s1_index];
        if (wb_we && wb_index == s1_index)   rd_entry = wb_data;
        if (cfg_we && cfg_index == s1_index) rd_entry = cfg_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1_pkt   <= '0;
            s2_pkt   <= '0;
            s2_entry <= '0;
        end else if (!out_stall) begin
            s1_valid <= grant_valid;
            s1_pkt   <= head[grant_port];
            s2_valid <= s1_valid;
            s2_pkt   <= s1_pkt;
            s2_entry <= rd_entry;
        end
    end

    // ---------------- WB: reduction and output ----------------
    logic [CntWidth-1:0]    e_expect, e_count, n_cnt, thresh;
    logic [WeightWidth-1:0] w_sum;
    logic [PayloadLen-1:0]  p_sum;
    logic                   is_red, done;
    logic [DataWidth-1:0]   emit_pkt, out_next;

    always_comb begin
        e_expect = s2_entry[ExpLsb +: CntWidth];
        e_count  = s2_entry[CntLsb +: CntWidth];
        n_cnt    = e_count + 1'b1;
        w_sum    = s2_entry[WaccLsb +: WeightWidth] + s2_pkt[WeightPos +: WeightWidth];
        p_sum    = s2_entry[PayloadLen-1:0] + s2_pkt[PayloadLen-1:0];
        thresh   = (e_expect == '0) ? CntWidth'(1) : e_expect;
        done     = (n_cnt >= thresh);
        is_red   = s2_pkt[ReductionBitPos];
        wb_we    = s2_valid && is_red && !out_stall;
        wb_data  = done ? {e_expect, {(EntryW-CntWidth){1'b0}}}
                        : {e_expect, n_cnt, w_sum, p_sum};
        // Combined packet keeps the header of the last contributor; weight and payload are replaced.
        emit_pkt = s2_pkt;
        emit_pkt[WeightPos +: WeightWidth] = w_sum;
        emit_pkt[PayloadLen-1:0]           = p_sum;
        out_next = '0;
        if (s2_valid) begin
            if (!is_red)   out_next = s2_pkt;
            else if (done) out_next = emit_pkt;
        end
    end

    // cfg is written last so it overrides a same-index WB write.
    always_ff @(posedge clk) begin
        if (wb_we)  red_table[wb_index]  <= wb_data;
        if (cfg_we) red_table[cfg_index] <= cfg_data;
    end

    always_ff @(posedge clk) begin
        if (rst)             out <= '0;
        else if (!out_stall) out <= out_next;
    end

    assign send = out[DataWidth-1];

endmodule
